// File: rtl/cordic_ci_master.sv
// Operand FIFO -> CORDIC slave load/run/capture sequencer -> result FIFO.
// Define CORDIC_MASTER_SIGN_FOLD_EN to clear operand bit 31 at issue.
module cordic_ci_master #(
  parameter int DEPTH   = 8,
  parameter int LATENCY = 16
) (
  input  logic        clock,
  input  logic        aclr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy,
  output logic        ci_aclr,
  output logic        ci_clk_en,
  output logic [31:0] ci_dataa,
  input  logic [31:0] ci_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    CAPTURE
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] iter;

  logic [31:0]   in_mem  [DEPTH];
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] in_wp, in_rp;
  logic [AW-1:0] out_wp, out_rp;
  logic [AW:0]   in_cnt, out_cnt;
  logic [AW:0]   out_cnt_nxt;

  logic          in_push, issue;
  logic          out_push, out_pop;
  logic          room, can_issue;
  logic [31:0]   in_head, op_load;

  assign in_ready  = !aclr && (in_cnt != FULL);
  assign in_push   = in_valid && in_ready;
  assign out_valid = (out_cnt != '0);
  assign out_pop   = out_valid && out_ready;
  assign out_push  = (state == CAPTURE);
  assign out_data  = out_valid ? out_mem[out_rp] : '0;
  assign busy      = (state != IDLE);
  assign in_head   = in_mem[in_rp];

  assign out_cnt_nxt = out_cnt
                     + (AW+1)'(out_push)
                     - (AW+1)'(out_pop);

`ifdef CORDIC_MASTER_SIGN_FOLD_EN
  assign op_load = {1'b0, in_head[30:0]};
`else
  assign op_load = in_head;
`endif

  // Re-issue from CAPTURE must leave space for the result being written now.
  assign room = (state == CAPTURE) ? (out_cnt_nxt < FULL)
                                   : (out_cnt < FULL);
  assign can_issue = (in_cnt != '0) && room;

  always_ff @(posedge clock) begin
    if (in_push)
      in_mem[in_wp] <= in_data;
    if (out_push)
      out_mem[out_wp] <= ci_result;
  end

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      in_wp   <= '0;
      in_rp   <= '0;
      in_cnt  <= '0;
      out_wp  <= '0;
      out_rp  <= '0;
      out_cnt <= '0;
    end else begin
      if (in_push)
        in_wp <= in_wp + AW'(1);
      if (issue)
        in_rp <= in_rp + AW'(1);
      in_cnt <= in_cnt
              + (AW+1)'(in_push)
              - (AW+1)'(issue);
      if (out_push)
        out_wp <= out_wp + AW'(1);
      if (out_pop)
        out_rp <= out_rp + AW'(1);
      out_cnt <= out_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_issue) begin
          state_nxt = LOAD;
          issue     = 1'b1;
        end
      end
      LOAD: state_nxt = RUN;
      RUN: begin
        if (iter == LAST)
          state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (can_issue) begin
          state_nxt = LOAD;
          issue     = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Slave controls are registered from the next state so they track state.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      state     <= IDLE;
      iter      <= '0;
      ci_aclr   <= 1'b1;
      ci_clk_en <= 1'b0;
      ci_dataa  <= '0;
    end else begin
      state     <= state_nxt;
      ci_aclr   <= (state_nxt == IDLE) || (state_nxt == LOAD);
      ci_clk_en <= (state_nxt == RUN);
      if (issue)
        ci_dataa <= op_load;
      if (state == LOAD)
        iter <= '0;
      else if (state == RUN)
        iter <= iter + CW'(1);
    end
  end

endmodule

// File: tb/tb_cordic_ci_master.sv
// Bench for cordic_ci_master: model slave, result scoreboard, directed
// timing scenarios and a randomized stream.
module tb_cordic_ci_master;

  logic        clock = 1'b0;
  logic        aclr = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic        ci_aclr, ci_clk_en;
  logic [31:0] out_data, ci_dataa, ci_result;

  logic [31:0] slv_op = '0;
  int          slv_idx = 0;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  logic [31:0] exp_q[$];
  int          pop_cyc[$];

  cordic_ci_master #(.DEPTH(8), .LATENCY(16)) dut (
    .clock    (clock),
    .aclr     (aclr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .ci_aclr  (ci_aclr),
    .ci_clk_en(ci_clk_en),
    .ci_dataa (ci_dataa),
    .ci_result(ci_result)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Model slave: result valid only once 16 enables follow a load.
  always @(posedge clock) begin
    if (ci_aclr) begin
      slv_op  <= ci_dataa;
      slv_idx <= 0;
    end else if (ci_clk_en) begin
      slv_idx <= slv_idx + 1;
    end
  end
  assign ci_result = (slv_idx == 16) ? slv_op + 32'd1 : 32'h0;

  function automatic logic [31:0] model(input logic [31:0] op);
`ifdef CORDIC_MASTER_SIGN_FOLD_EN
    return {1'b0, op[30:0]} + 32'd1;
`else
    return op + 32'd1;
`endif
  endfunction

  always @(negedge clock) begin
    if (!aclr && out_valid && out_ready) begin
      logic [31:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL unexpected_result observed=%h expected=none",
               out_data);
      end else begin
        e = exp_q.pop_front();
        assert (out_data === e) else begin
          n_err++;
          $error("FAIL result_order observed=%h expected=%h",
                 out_data, e);
        end
      end
      pop_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (rand_rdy)
      out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] d);
    int b = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && b < 400) begin
      tick();
      b++;
    end
    if (!in_ready) begin
      n_checks++;
      n_err++;
      $error("FAIL push_timeout observed=in_ready_low expected=accept");
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(d));
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick();
      b++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $error("FAIL drain_timeout observed=%0d expected=0", exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  initial begin
    int t0;
    int b;
    bit found;
    logic [31:0] d;

    repeat (2) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ci_aclr", 32'(ci_aclr), 32'd1);
    chk("rst_ci_clk_en", 32'(ci_clk_en), 32'd0);
    chk("rst_ci_dataa", ci_dataa, 32'd0);
    aclr = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Single operation timing
    push(32'h3F00_0000);
    t0 = cyc;
    chk("t_idle", 32'(busy), 32'd0);
    tick();
    chk("t_load_busy", 32'(busy), 32'd1);
    chk("t_load_aclr", 32'(ci_aclr), 32'd1);
    chk("t_load_dataa", ci_dataa, 32'h3F00_0000);
    tick();
    chk("t_run_aclr", 32'(ci_aclr), 32'd0);
    chk("t_run_en", 32'(ci_clk_en), 32'd1);
    b = 0;
    while (!out_valid && b < 100) begin
      tick();
      b++;
    end
    chk("t_latency", 32'(cyc - t0), 32'd19);
    chk("t_out_data", out_data, 32'h3F00_0001);
    chk("t_idle_after", 32'(busy), 32'd0);
    out_ready = 1'b1;
    drain(50);

    // Streaming throughput
    pop_cyc.delete();
    for (int i = 0; i < 10; i++)
      push(32'h3F00_0000 + 32'(i));
    drain(400);
    chk("s_count", 32'(pop_cyc.size()), 32'd10);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk($sformatf("s_gap%0d", i),
          32'(pop_cyc[i] - pop_cyc[i-1]), 32'd18);

    // Backpressure: 8 results buffered, 8 operands queued
    out_ready = 1'b0;
    pop_cyc.delete();
    for (int i = 0; i < 16; i++)
      push(32'h4000_0000 + 32'(i));
    repeat (40) tick();
    in_valid = 1'b1;
    in_data  = 32'h4000_0010;
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    chk("bp_head", out_data, 32'h4000_0001);
    out_ready = 1'b1;
    b = 0;
    while (!in_ready && b < 60) begin
      tick();
      b++;
    end
    chk("bp_ready_back", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    exp_q.push_back(model(32'h4000_0010));
    drain(600);
    chk("bp_count", 32'(pop_cyc.size()), 32'd17);
    if (pop_cyc.size() >= 9) begin
      chk("bp_burst", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
      chk("bp_gap", 32'(pop_cyc[8] - pop_cyc[7] > 1), 32'd1);
    end

    // Pop coinciding with a CAPTURE push
    out_ready = 1'b0;
    pop_cyc.delete();
    for (int i = 0; i < 10; i++)
      push(32'h4100_0000 + 32'(i));
    repeat (8 * 18 + 30) tick();
    chk("sim_idle", 32'(busy), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    found = 1'b0;
    b = 0;
    while (!found && b < 60) begin
      if (busy && !ci_aclr && !ci_clk_en)
        found = 1'b1;
      else
        tick();
      b++;
    end
    chk("sim_capture", 32'(found), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    repeat (40) tick();
    chk("sim_idle2", 32'(busy), 32'd0);
    chk("sim_pops", 32'(pop_cyc.size()), 32'd2);
    pop_cyc.delete();
    out_ready = 1'b1;
    drain(100);
    chk("sim_drain", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8)
      chk("sim_burst", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

    // Reset during RUN cycle 7
    out_ready = 1'b0;
    push(32'h4200_0000);
    b = 0;
    while (!out_valid && b < 40) begin
      tick();
      b++;
    end
    push(32'h4200_0001);
    tick();
    tick();
    repeat (6) tick();
    chk("mr_running", 32'(ci_clk_en), 32'd1);
    aclr = 1'b1;
    #1;
    chk("mr_ci_aclr", 32'(ci_aclr), 32'd1);
    chk("mr_ci_clk_en", 32'(ci_clk_en), 32'd0);
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_dataa", ci_dataa, 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    tick();
    tick();
    aclr = 1'b0;
    out_ready = 1'b1;
    pop_cyc.delete();
    repeat (40) tick();
    chk("mr_no_stale", 32'(pop_cyc.size()), 32'd0);
    chk("mr_busy_after", 32'(busy), 32'd0);

    // Sign handling of a negative angle
    push(32'hBF00_0000);
    tick();
`ifdef CORDIC_MASTER_SIGN_FOLD_EN
    chk("fold_dataa", ci_dataa, 32'h3F00_0000);
`else
    chk("fold_dataa", ci_dataa, 32'hBF00_0000);
`endif
    drain(60);

    // Randomized operands and consumer stalls
    rand_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      d = $urandom;
      push(d);
      repeat ($urandom_range(0, 20)) tick();
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    drain(2000);
    repeat (5) tick();
    chk("rand_idle", 32'(busy), 32'd0);
    chk("rand_empty", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
